// File: rtl/dot11_frame_buffer.sv
// Store-and-forward buffer behind the dot11 receiver. Each frame is held until its FCS verdict arrives;
// good frames stream out on a valid/ready byte port. Define FRAME_BUF_LEN_HDR_EN to prefix a 2-byte length header.
module dot11_frame_buffer #(
   parameter int unsigned DEPTH          = 4096,
   parameter int unsigned ADDR_W         = 12,
   parameter int unsigned LEN_FIFO_DEPTH = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              frame_start,
   input  logic [7:0]        byte_in,
   input  logic              byte_in_strobe,
   input  logic              fcs_in_strobe,
   input  logic              fcs_ok,
   output logic [7:0]        m_data,
   output logic              m_valid,
   output logic              m_last,
   input  logic              m_ready,
   output logic [15:0]       frame_count,
   output logic [15:0]       drop_count,
   output logic [ADDR_W:0]   buf_level
);

   localparam int unsigned PTR_W = ADDR_W + 1;
   localparam int unsigned LEN_W = 12;
   localparam int unsigned LF_W  = LEN_W + 1;
   localparam int unsigned LF_AW = $clog2(LEN_FIFO_DEPTH);
   localparam int unsigned LF_PW = LF_AW + 1;

`ifdef FRAME_BUF_LEN_HDR_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RECV = 2'd1, S_HDR = 2'd2} state_t;
`else
   typedef enum logic {S_IDLE = 1'b0, S_RECV = 1'b1} state_t;
`endif

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   wr_tmp_q, wr_tmp_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   rd_ld_q, rd_ld_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovf_q, ovf_d;
   logic [15:0]        frame_count_q, frame_count_d;
   logic [15:0]        drop_count_q, drop_count_d;
   logic [PTR_W-1:0]   buf_level_q, buf_level_d;
   logic [7:0]         m_data_q, m_data_d;
   logic               m_valid_q, m_valid_d;
   logic               m_last_q, m_last_d;
   logic [LF_PW-1:0]   lf_wr_q, lf_wr_d;
   logic [LF_PW-1:0]   lf_rd_q, lf_rd_d;
   logic [LF_PW-1:0]   lf_ld_q, lf_ld_d;
   logic [LF_W-1:0]    ld_cnt_q, ld_cnt_d;
   logic [LF_W-1:0]    lf_mem_q [LEN_FIFO_DEPTH];
   logic [7:0]         mem_q [DEPTH];
`ifdef FRAME_BUF_LEN_HDR_EN
   logic               hdr_idx_q, hdr_idx_d;
   logic [LEN_W-1:0]   hdr_len_q, hdr_len_d;
   logic [PTR_W-1:0]   hdr_end_q, hdr_end_d;
   logic               fs_pend_q, fs_pend_d;
`endif

   logic               fs_c, bs_c, fcs_c;
   logic               lf_full_c, ld_avail_c;
   logic [LF_W-1:0]    ld_len_c;
   logic               mem_we_c;
   logic [ADDR_W-1:0]  mem_waddr_c;
   logic [7:0]         mem_wdata_c;
   logic               lf_push_c;
   logic [LF_W-1:0]    lf_push_val_c;
   logic [PTR_W-1:0]   wr_tmp_n;
   logic [LEN_W-1:0]   len_n;
   logic               ovf_n;
   logic               start_c;
   logic [PTR_W-1:0]   start_base_c;

   assign fs_c       = enable & frame_start;
   assign bs_c       = enable & byte_in_strobe;
   assign fcs_c      = enable & fcs_in_strobe;
   assign lf_full_c  = (lf_wr_q - lf_rd_q) == LF_PW'(LEN_FIFO_DEPTH);
   assign ld_avail_c = (lf_ld_q != lf_wr_q);
   assign ld_len_c   = lf_mem_q[lf_ld_q[LF_AW-1:0]];

   // Next-state: receive FSM (speculative write side) and output stage (read side)
   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      wr_tmp_d      = wr_tmp_q;
      rd_ptr_d      = rd_ptr_q;
      rd_ld_d       = rd_ld_q;
      len_d         = len_q;
      ovf_d         = ovf_q;
      frame_count_d = frame_count_q;
      drop_count_d  = drop_count_q;
      m_data_d      = m_data_q;
      m_valid_d     = m_valid_q;
      m_last_d      = m_last_q;
      lf_wr_d       = lf_wr_q;
      lf_rd_d       = lf_rd_q;
      lf_ld_d       = lf_ld_q;
      ld_cnt_d      = ld_cnt_q;
`ifdef FRAME_BUF_LEN_HDR_EN
      hdr_idx_d     = hdr_idx_q;
      hdr_len_d     = hdr_len_q;
      hdr_end_d     = hdr_end_q;
      fs_pend_d     = fs_pend_q;
`endif
      mem_we_c      = 1'b0;
      mem_waddr_c   = wr_tmp_q[ADDR_W-1:0];
      mem_wdata_c   = byte_in;
      lf_push_c     = 1'b0;
      lf_push_val_c = '0;
      wr_tmp_n      = wr_tmp_q;
      len_n         = len_q;
      ovf_n         = ovf_q;
      start_c       = 1'b0;
      start_base_c  = wr_ptr_q;

      case (state_q)
         S_IDLE: begin
            if (fs_c) start_c = 1'b1;
         end
         S_RECV: begin
            // A byte arriving with the verdict belongs to the frame being judged
            if (bs_c) begin
               if ((wr_tmp_q - rd_ptr_q) < PTR_W'(DEPTH)) begin
                  mem_we_c = 1'b1;
                  wr_tmp_n = wr_tmp_q + PTR_W'(1);
                  if (len_q != '1) len_n = len_q + LEN_W'(1);
               end else begin
                  ovf_n = 1'b1;
               end
            end
            wr_tmp_d = wr_tmp_n;
            len_d    = len_n;
            ovf_d    = ovf_n;
            if (fcs_c) begin
               state_d = S_IDLE;
               if (fcs_ok && !ovf_n && (len_n != '0) && !lf_full_c) begin
`ifdef FRAME_BUF_LEN_HDR_EN
                  state_d   = S_HDR;
                  hdr_idx_d = 1'b0;
                  hdr_len_d = len_n;
                  hdr_end_d = wr_tmp_n;
                  fs_pend_d = fs_c;
`else
                  wr_ptr_d      = wr_tmp_n;
                  lf_push_c     = 1'b1;
                  lf_push_val_c = LF_W'(len_n);
                  frame_count_d = sat_inc(frame_count_q);
                  start_c       = fs_c;
                  start_base_c  = wr_tmp_n;
`endif
               end else begin
                  wr_tmp_d     = wr_ptr_q;
                  drop_count_d = sat_inc(drop_count_q);
                  start_c      = fs_c;
               end
            end else if (fs_c) begin
               drop_count_d = sat_inc(drop_count_q);
               start_c      = 1'b1;
            end
         end
`ifdef FRAME_BUF_LEN_HDR_EN
         S_HDR: begin
            mem_we_c = 1'b1;
            if (!hdr_idx_q) begin
               mem_waddr_c = wr_ptr_q[ADDR_W-1:0];
               mem_wdata_c = hdr_len_q[7:0];
               hdr_idx_d   = 1'b1;
               if (fs_c) fs_pend_d = 1'b1;
            end else begin
               mem_waddr_c   = wr_ptr_q[ADDR_W-1:0] + ADDR_W'(1);
               mem_wdata_c   = {4'b0, hdr_len_q[11:8]};
               wr_ptr_d      = hdr_end_q;
               wr_tmp_d      = hdr_end_q;
               lf_push_c     = 1'b1;
               lf_push_val_c = LF_W'(hdr_len_q) + LF_W'(2);
               frame_count_d = sat_inc(frame_count_q);
               state_d       = S_IDLE;
               fs_pend_d     = 1'b0;
               start_c       = fs_pend_q | fs_c;
               start_base_c  = hdr_end_q;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // New frame opens from the committed write pointer
      if (start_c) begin
         state_d = S_RECV;
         len_d   = '0;
         ovf_d   = 1'b0;
`ifdef FRAME_BUF_LEN_HDR_EN
         if ((start_base_c - rd_ptr_q) > PTR_W'(DEPTH - 2)) begin
            ovf_d    = 1'b1;
            wr_tmp_d = start_base_c;
         end else begin
            wr_tmp_d = start_base_c + PTR_W'(2);
         end
`else
         wr_tmp_d = start_base_c;
`endif
      end

      if (lf_push_c) lf_wr_d = lf_wr_q + LF_PW'(1);

      // Consumer side: space is released and the length entry popped only on acceptance
      if (m_valid_q && m_ready) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (m_last_q) lf_rd_d = lf_rd_q + LF_PW'(1);
      end

      // Output stage refill runs ahead of the pop pointer so frame boundaries cost no bubble
      if (!m_valid_q || m_ready) begin
         if (ld_avail_c) begin
            m_valid_d = 1'b1;
            m_data_d  = mem_q[rd_ld_q[ADDR_W-1:0]];
            rd_ld_d   = rd_ld_q + PTR_W'(1);
            if (ld_cnt_q == ld_len_c - LF_W'(1)) begin
               m_last_d = 1'b1;
               ld_cnt_d = '0;
               lf_ld_d  = lf_ld_q + LF_PW'(1);
            end else begin
               m_last_d = 1'b0;
               ld_cnt_d = ld_cnt_q + LF_W'(1);
            end
         end else begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
         end
      end

      buf_level_d = wr_ptr_d - rd_ptr_d;
   end

   // State and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_IDLE;
         wr_ptr_q      <= '0;
         wr_tmp_q      <= '0;
         rd_ptr_q      <= '0;
         rd_ld_q       <= '0;
         len_q         <= '0;
         ovf_q         <= 1'b0;
         frame_count_q <= '0;
         drop_count_q  <= '0;
         buf_level_q   <= '0;
         m_data_q      <= '0;
         m_valid_q     <= 1'b0;
         m_last_q      <= 1'b0;
         lf_wr_q       <= '0;
         lf_rd_q       <= '0;
         lf_ld_q       <= '0;
         ld_cnt_q      <= '0;
         for (int unsigned i = 0; i < LEN_FIFO_DEPTH; i++) lf_mem_q[i] <= '0;
`ifdef FRAME_BUF_LEN_HDR_EN
         hdr_idx_q     <= 1'b0;
         hdr_len_q     <= '0;
         hdr_end_q     <= '0;
         fs_pend_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         wr_tmp_q      <= wr_tmp_d;
         rd_ptr_q      <= rd_ptr_d;
         rd_ld_q       <= rd_ld_d;
         len_q         <= len_d;
         ovf_q         <= ovf_d;
         frame_count_q <= frame_count_d;
         drop_count_q  <= drop_count_d;
         buf_level_q   <= buf_level_d;
         m_data_q      <= m_data_d;
         m_valid_q     <= m_valid_d;
         m_last_q      <= m_last_d;
         lf_wr_q       <= lf_wr_d;
         lf_rd_q       <= lf_rd_d;
         lf_ld_q       <= lf_ld_d;
         ld_cnt_q      <= ld_cnt_d;
         if (lf_push_c) lf_mem_q[lf_wr_q[LF_AW-1:0]] <= lf_push_val_c;
`ifdef FRAME_BUF_LEN_HDR_EN
         hdr_idx_q     <= hdr_idx_d;
         hdr_len_q     <= hdr_len_d;
         hdr_end_q     <= hdr_end_d;
         fs_pend_q     <= fs_pend_d;
`endif
      end
   end

   // Byte storage, no reset needed
   always_ff @(posedge clock) begin
      if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
   end

   assign m_data      = m_data_q;
   assign m_valid     = m_valid_q;
   assign m_last      = m_last_q;
   assign frame_count = frame_count_q;
   assign drop_count  = drop_count_q;
   assign buf_level   = buf_level_q;

endmodule

// File: tb/tb_dot11_frame_buffer.sv
// Directed bench for dot11_frame_buffer (DEPTH=16); expectations include the length header when FRAME_BUF_LEN_HDR_EN is defined.
module tb_dot11_frame_buffer;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;
`ifdef FRAME_BUF_LEN_HDR_EN
   localparam int HB = 2;
`else
   localparam int HB = 0;
`endif

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b1;
   logic              frame_start = 1'b0;
   logic [7:0]        byte_in = '0;
   logic              byte_in_strobe = 1'b0;
   logic              fcs_in_strobe = 1'b0;
   logic              fcs_ok = 1'b0;
   logic [7:0]        m_data;
   logic              m_valid;
   logic              m_last;
   logic              m_ready = 1'b0;
   logic [15:0]       frame_count;
   logic [15:0]       drop_count;
   logic [ADDR_W:0]   buf_level;

   int n_total = 0;
   int n_bad   = 0;
   int valid_seen = 0;
   int stall_viol = 0;
   logic       stall_prev = 1'b0;
   logic [9:0] prev_out = '0;
   logic [8:0] rx_q[$];
   logic [8:0] exp_q[$];
   logic [7:0] frm_q[$];

   dot11_frame_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_FIFO_DEPTH(8)) dut (
      .clock(clock), .reset(reset), .enable(enable), .frame_start(frame_start),
      .byte_in(byte_in), .byte_in_strobe(byte_in_strobe), .fcs_in_strobe(fcs_in_strobe),
      .fcs_ok(fcs_ok), .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .frame_count(frame_count), .drop_count(drop_count), .buf_level(buf_level)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Output observer on the falling edge: accepted bytes and stall stability
   always @(negedge clock) begin
      if (!reset) begin
         if (m_valid) valid_seen <= valid_seen + 1;
         if (stall_prev && ({m_valid, m_last, m_data} !== prev_out)) stall_viol <= stall_viol + 1;
         stall_prev <= m_valid && !m_ready;
         prev_out   <= {m_valid, m_last, m_data};
         if (m_valid && m_ready) rx_q.push_back({m_last, m_data});
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic fs, input logic bs, input logic [7:0] b, input logic fcs, input logic ok);
      frame_start    = fs;
      byte_in_strobe = bs;
      byte_in        = b;
      fcs_in_strobe  = fcs;
      fcs_ok         = ok;
      cyc();
      frame_start    = 1'b0;
      byte_in_strobe = 1'b0;
      fcs_in_strobe  = 1'b0;
      fcs_ok         = 1'b0;
   endtask

   // Appends the expected output of frm_q (with header when enabled) to exp_q
   task automatic exp_frame();
      int n;
      n = frm_q.size();
      if (HB != 0) begin
         exp_q.push_back({1'b0, 8'(n)});
         exp_q.push_back({1'b0, 4'b0, 4'(n >> 8)});
      end
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), frm_q[i]});
      frm_q.delete();
   endtask

   task automatic wait_rx(input string tag, input int n);
      int c;
      c = 0;
      while (rx_q.size() < n && c < 400) begin
         cyc();
         c++;
      end
      check_eq(tag, rx_q.size(), n);
   endtask

   task automatic compare_rx(input string tag);
      int n;
      check_eq({tag, "_count"}, rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check_eq($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
      rx_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int c;
      int vs0;
      int lasts;
      repeat (3) cyc();
      reset = 1'b0;
      cyc();

      // Reset state
      check_eq("rst_m_valid", m_valid, 0);
      check_eq("rst_m_last", m_last, 0);
      check_eq("rst_m_data", m_data, 0);
      check_eq("rst_buf_level", buf_level, 0);
      check_eq("rst_frame_count", frame_count, 0);
      check_eq("rst_drop_count", drop_count, 0);

      // Good frame, held in the buffer until the consumer becomes ready
      drive(1, 0, 8'h00, 0, 0);
      drive(0, 1, 8'hAA, 0, 0);
      drive(0, 1, 8'hBB, 0, 0);
      drive(0, 1, 8'hCC, 0, 0);
      drive(0, 1, 8'hDD, 0, 0);
      drive(0, 0, 8'h00, 1, 1);
      c = 0;
      while (!m_valid && c < 20) begin
         cyc();
         c++;
      end
      check_eq("good_valid_latency", c, 1 + HB);
      check_eq("good_frame_count", frame_count, 1);
      check_eq("good_buf_level", buf_level, 4 + HB);
      frm_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      exp_frame();
      m_ready = 1'b1;
      wait_rx("good_rx_wait", 4 + HB);
      repeat (2) cyc();
      compare_rx("good");
      check_eq("good_drop_count", drop_count, 0);
      check_eq("good_buf_level_end", buf_level, 0);

      // Bad FCS: nothing may reach the output
      vs0 = valid_seen;
      drive(1, 0, 8'h00, 0, 0);
      drive(0, 1, 8'hAA, 0, 0);
      drive(0, 1, 8'hBB, 0, 0);
      drive(0, 1, 8'hCC, 0, 0);
      drive(0, 1, 8'hDD, 0, 0);
      drive(0, 0, 8'h00, 1, 0);
      repeat (10) cyc();
      check_eq("bad_valid_seen", valid_seen - vs0, 0);
      check_eq("bad_rx_count", rx_q.size(), 0);
      check_eq("bad_drop_count", drop_count, 1);
      check_eq("bad_buf_level", buf_level, 0);

      // Overflow: 20 bytes into a 16-byte store, then a good frame with a disabled strobe in it
      drive(1, 0, 8'h00, 0, 0);
      for (int i = 0; i < 20; i++) drive(0, 1, 8'(8'h80 + i), 0, 0);
      drive(0, 0, 8'h00, 1, 1);
      repeat (4) cyc();
      check_eq("ovf_drop_count", drop_count, 2);
      check_eq("ovf_buf_level", buf_level, 0);
      check_eq("ovf_rx_count", rx_q.size(), 0);
      drive(1, 0, 8'h00, 0, 0);
      drive(0, 1, 8'h01, 0, 0);
      enable = 1'b0;
      drive(0, 1, 8'hEE, 0, 0);
      enable = 1'b1;
      drive(0, 1, 8'h02, 0, 0);
      drive(0, 1, 8'h03, 0, 1);
      drive(0, 0, 8'h00, 1, 1);
      frm_q = '{8'h01, 8'h02, 8'h03};
      exp_frame();
      wait_rx("ovf_rx_wait", 3 + HB);
      compare_rx("after_ovf");
      check_eq("after_ovf_frame_count", frame_count, 2);

      // Abort by a second frame_start; last byte arrives together with the verdict
      drive(1, 0, 8'h00, 0, 0);
      drive(0, 1, 8'h11, 0, 0);
      drive(0, 1, 8'h22, 0, 0);
      drive(1, 0, 8'h00, 0, 0);
      drive(0, 1, 8'h33, 0, 0);
      drive(0, 1, 8'h44, 1, 1);
      frm_q = '{8'h33, 8'h44};
      exp_frame();
      wait_rx("abort_rx_wait", 2 + HB);
      repeat (2) cyc();
      compare_rx("abort");
      check_eq("abort_drop_count", drop_count, 3);
      check_eq("abort_frame_count", frame_count, 3);

      // Two frames queued (second started on the first one's verdict), then drained under backpressure
      m_ready = 1'b0;
      drive(1, 0, 8'h00, 0, 0);
      for (int i = 0; i < 5; i++) drive(0, 1, 8'(8'h50 + i), 0, 0);
      drive(1, 0, 8'h00, 1, 1);
      repeat (HB) cyc();
      for (int i = 0; i < 3; i++) drive(0, 1, 8'(8'h60 + i), 0, 0);
      drive(0, 0, 8'h00, 1, 1);
      repeat (4) cyc();
      check_eq("bp_frame_count", frame_count, 5);
      check_eq("bp_buf_level", buf_level, 8 + 2 * HB);
      frm_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
      exp_frame();
      frm_q = '{8'h60, 8'h61, 8'h62};
      exp_frame();
      c = 0;
      while (rx_q.size() < 8 + 2 * HB && c < 400) begin
         m_ready = ~m_ready;
         cyc();
         c++;
      end
      check_eq("bp_rx_wait", rx_q.size(), 8 + 2 * HB);
      m_ready = 1'b1;
      repeat (2) cyc();
      lasts = 0;
      foreach (rx_q[i]) if (rx_q[i][8]) lasts++;
      check_eq("bp_last_count", lasts, 2);
      compare_rx("bp");
      check_eq("bp_stall_stable", stall_viol, 0);
      check_eq("bp_buf_level_end", buf_level, 0);
      check_eq("bp_drop_count", drop_count, 3);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
